// File: rtl/cla_addsub_pipe_if.sv
// Handshake and data bundle for cla_addsub_pipe: operand beat in, result beat out.
// master drives operands and OUT_READY; slave is the adder/subtractor itself.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 15
);
  logic             IN_VALID;
  logic             IN_READY;
  logic             ADDSUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             OVF;
  logic             ZERO;
  logic             NEG;

  modport master (
    output IN_VALID, ADDSUB, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT, OVF, ZERO, NEG
  );

  modport slave (
    input  IN_VALID, ADDSUB, A, B, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT, OVF, ZERO, NEG
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional macro CLA_ADDSUB_SATURATE_EN clamps SUM on signed overflow.
module cla_addsub_pipe #(
  parameter int WIDTH = 15,
  parameter int GROUP = 3
) (
  input logic            CLK,
  input logic            RST_N,
  cla_addsub_pipe_if.slave bus
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_cin_q, s1_cin_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [NG-1:0]    s1_gp_q, s1_gp_d;
  logic [NG-1:0]    s1_gg_q, s1_gg_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             s2_load;
  logic             in_ready;
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic [NG-1:0]    gp_in, gg_in;
  logic [NG:0]      grp_c;
  logic             c_acc, p_acc, c_run;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] raw_sum, final_sum;
  logic             raw_ovf;

  // Stage 2 can take a new beat when empty or when its result leaves this cycle.
  assign s2_load      = !out_valid_q || bus.OUT_READY;
  assign in_ready     = !s1_valid_q || s2_load;
  assign bus.IN_READY = in_ready;

  always_comb begin
    b_eff = bus.B ^ {WIDTH{bus.ADDSUB}};
    p_in  = bus.A ^ b_eff;
    g_in  = bus.A & b_eff;
    gp_in = '1;
    gg_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gg_in[i/GROUP] = g_in[i] | (p_in[i] & gg_in[i/GROUP]);
      gp_in[i/GROUP] = gp_in[i/GROUP] & p_in[i];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cin_d   = s1_cin_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_gp_d    = s1_gp_q;
    s1_gg_d    = s1_gg_q;
    if (in_ready) begin
      s1_valid_d = bus.IN_VALID;
      if (bus.IN_VALID) begin
        s1_cin_d = bus.ADDSUB;
        s1_p_d   = p_in;
        s1_g_d   = g_in;
        s1_gp_d  = gp_in;
        s1_gg_d  = gg_in;
      end
    end
  end

  // Each group carry is a flat sum-of-products over lower groups and carry-in.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_cin_q;
    c_acc    = 1'b0;
    p_acc    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c_acc = s1_gg_q[k];
      p_acc = s1_gp_q[k];
      for (int j = NG - 1; j >= 0; j--) begin
        if (j < k) begin
          c_acc = c_acc | (p_acc & s1_gg_q[j]);
          p_acc = p_acc & s1_gp_q[j];
        end
      end
      grp_c[k+1] = c_acc | (p_acc & s1_cin_q);
    end
  end

  always_comb begin
    bit_c   = '0;
    raw_sum = '0;
    c_run   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i % GROUP == 0) c_run = grp_c[i/GROUP];
      bit_c[i]   = c_run;
      raw_sum[i] = s1_p_q[i] ^ c_run;
      c_run      = s1_g_q[i] | (s1_p_q[i] & c_run);
    end
    raw_ovf   = bit_c[WIDTH-1] ^ grp_c[NG];
    final_sum = raw_sum;
`ifdef CLA_ADDSUB_SATURATE_EN
    // On overflow both operand MSBs agree, so g at the MSB equals the sign of A.
    if (raw_ovf)
      final_sum = s1_g_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = final_sum;
        cout_d = grp_c[NG];
        ovf_d  = raw_ovf;
        zero_d = (final_sum == '0);
        neg_d  = final_sum[WIDTH-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s1_cin_q    <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_gp_q     <= '0;
      s1_gg_q     <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cin_q    <= s1_cin_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_gp_q     <= s1_gp_d;
      s1_gg_q     <= s1_gg_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.SUM       = sum_q;
  assign bus.COUT      = cout_q;
  assign bus.OVF       = ovf_q;
  assign bus.ZERO      = zero_q;
  assign bus.NEG       = neg_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: one GROUP=3 instance plus GROUP=1/4/15 twins on the same stimulus.
// Expected values follow CLA_ADDSUB_SATURATE_EN when it is defined.
module tb_cla_addsub_pipe;

  localparam int W = 15;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  typedef struct packed {
    logic         addsub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   test_count = 0;
  int   fail_count = 0;
  exp_t exp_q[$];
  bit   sweep_done;

  cla_addsub_pipe_if #(.WIDTH(W)) bus ();
  cla_addsub_pipe_if #(.WIDTH(W)) bus_g1 ();
  cla_addsub_pipe_if #(.WIDTH(W)) bus_g4 ();
  cla_addsub_pipe_if #(.WIDTH(W)) bus_g15 ();

  cla_addsub_pipe #(.WIDTH(W), .GROUP(3))  dut     (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  cla_addsub_pipe #(.WIDTH(W), .GROUP(1))  dut_g1  (.CLK(CLK), .RST_N(RST_N), .bus(bus_g1));
  cla_addsub_pipe #(.WIDTH(W), .GROUP(4))  dut_g4  (.CLK(CLK), .RST_N(RST_N), .bus(bus_g4));
  cla_addsub_pipe #(.WIDTH(W), .GROUP(15)) dut_g15 (.CLK(CLK), .RST_N(RST_N), .bus(bus_g15));

  assign bus_g1.IN_VALID   = bus.IN_VALID;
  assign bus_g1.ADDSUB     = bus.ADDSUB;
  assign bus_g1.A          = bus.A;
  assign bus_g1.B          = bus.B;
  assign bus_g1.OUT_READY  = bus.OUT_READY;
  assign bus_g4.IN_VALID   = bus.IN_VALID;
  assign bus_g4.ADDSUB     = bus.ADDSUB;
  assign bus_g4.A          = bus.A;
  assign bus_g4.B          = bus.B;
  assign bus_g4.OUT_READY  = bus.OUT_READY;
  assign bus_g15.IN_VALID  = bus.IN_VALID;
  assign bus_g15.ADDSUB    = bus.ADDSUB;
  assign bus_g15.A         = bus.A;
  assign bus_g15.B         = bus.B;
  assign bus_g15.OUT_READY = bus.OUT_READY;

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t refModel(input logic addsub, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         r;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx     = b ^ {W{addsub}};
    full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, addsub};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
`ifdef CLA_ADDSUB_SATURATE_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.sum == '0);
    r.neg  = r.sum[W-1];
    return r;
  endfunction

  function automatic vec_t mkVec(input logic addsub, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] sum, input logic cout, input logic ovf,
                                 input logic zero, input logic neg);
    vec_t v;
    v.addsub = addsub;
    v.a      = a;
    v.b      = b;
    v.e      = '{sum: sum, cout: cout, ovf: ovf, zero: zero, neg: neg};
    return v;
  endfunction

  // Present one beat, hold it until accepted, and record its expected result.
  task automatic applyStimulus(input logic addsub, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int waited = 0;
    @(negedge CLK);
    bus.IN_VALID = 1'b1;
    bus.ADDSUB   = addsub;
    bus.A        = a;
    bus.B        = b;
    #1;
    while (!bus.IN_READY && waited < 50) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    checkOutput("beat_accepted", {15'b0, bus.IN_READY}, 16'h0001);
    if (bus.IN_READY) exp_q.push_back(e);
    @(posedge CLK);
  endtask

  task automatic goIdle();
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask

  // Monitor: compares every transferred result against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", {1'b0, bus.SUM}, 16'h0000);
          if (bus.SUM == '0) begin
            fail_count++;
            $display("[TB] FAIL unexpected_result: got a result beat, expected none");
          end
        end else begin
          e = exp_q.pop_front();
          checkOutput("sum",   {1'b0, bus.SUM}, {1'b0, e.sum});
          checkOutput("flags", {12'b0, bus.COUT, bus.OVF, bus.ZERO, bus.NEG},
                               {12'b0, e.cout, e.ovf, e.zero, e.neg});
          checkOutput("g1_result",  {bus_g1.OUT_VALID, bus_g1.SUM},   {1'b1, e.sum});
          checkOutput("g1_flags",   {12'b0, bus_g1.COUT, bus_g1.OVF, bus_g1.ZERO, bus_g1.NEG},
                                    {12'b0, e.cout, e.ovf, e.zero, e.neg});
          checkOutput("g4_result",  {bus_g4.OUT_VALID, bus_g4.SUM},   {1'b1, e.sum});
          checkOutput("g4_flags",   {12'b0, bus_g4.COUT, bus_g4.OVF, bus_g4.ZERO, bus_g4.NEG},
                                    {12'b0, e.cout, e.ovf, e.zero, e.neg});
          checkOutput("g15_result", {bus_g15.OUT_VALID, bus_g15.SUM}, {1'b1, e.sum});
          checkOutput("g15_flags",  {12'b0, bus_g15.COUT, bus_g15.OVF, bus_g15.ZERO, bus_g15.NEG},
                                    {12'b0, e.cout, e.ovf, e.zero, e.neg});
        end
      end
    end
  end

  initial begin
    vec_t vecs[9];
    int   waited;
    logic addsub;
    logic [W-1:0] ra, rb;

    // Hand-computed directed vectors; saturating build differs only on overflow cases.
    vecs[0] = mkVec(1'b0, 15'h0005, 15'h0003, 15'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CLA_ADDSUB_SATURATE_EN
    vecs[1] = mkVec(1'b0, 15'h3FFF, 15'h0001, 15'h3FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[4] = mkVec(1'b1, 15'h4000, 15'h0001, 15'h4000, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[8] = mkVec(1'b0, 15'h4000, 15'h4000, 15'h4000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    vecs[1] = mkVec(1'b0, 15'h3FFF, 15'h0001, 15'h4000, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[4] = mkVec(1'b1, 15'h4000, 15'h0001, 15'h3FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[8] = mkVec(1'b0, 15'h4000, 15'h4000, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
    vecs[2] = mkVec(1'b1, 15'h0000, 15'h0001, 15'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[3] = mkVec(1'b1, 15'h0005, 15'h0005, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[5] = mkVec(1'b0, 15'h7FFF, 15'h0001, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6] = mkVec(1'b0, 15'h2AAA, 15'h1555, 15'h3FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7] = mkVec(1'b1, 15'h0003, 15'h0007, 15'h7FFC, 1'b0, 1'b0, 1'b0, 1'b1);

    RST_N         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.ADDSUB    = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.OUT_READY = 1'b1;
    #12;
    checkOutput("reset_out_valid", {15'b0, bus.OUT_VALID}, 16'h0000);
    checkOutput("reset_sum",       {1'b0, bus.SUM}, 16'h0000);
    checkOutput("reset_flags",     {12'b0, bus.COUT, bus.OVF, bus.ZERO, bus.NEG}, 16'h0000);
    checkOutput("reset_in_ready",  {15'b0, bus.IN_READY}, 16'h0001);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vectors back-to-back at full throughput.
    foreach (vecs[i]) applyStimulus(vecs[i].addsub, vecs[i].a, vecs[i].b, vecs[i].e);
    goIdle();
    repeat (4) @(negedge CLK);

    // Backpressure: four beats with the consumer stalled for three cycles.
    bus.OUT_READY = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          applyStimulus(1'b0, W'(k), W'(k), '{sum: W'(2*k), cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
        goIdle();
      end
      begin
        waited = 0;
        @(negedge CLK);
        #1;
        while (!bus.OUT_VALID && waited < 20) begin
          @(negedge CLK);
          #1;
          waited++;
        end
        checkOutput("bp_first_valid", {15'b0, bus.OUT_VALID}, 16'h0001);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) begin
            @(negedge CLK);
            #1;
          end
          checkOutput("bp_in_ready_low", {15'b0, bus.IN_READY}, 16'h0000);
          checkOutput("bp_sum_hold",     {bus.OUT_VALID, bus.SUM}, 16'h8002);
        end
        @(negedge CLK);
        bus.OUT_READY = 1'b1;
        #1;
        checkOutput("bp_stream_0", {15'b0, bus.OUT_VALID}, 16'h0001);
        for (int k = 1; k < 4; k++) begin
          @(negedge CLK);
          #1;
          checkOutput("bp_stream_gap", {15'b0, bus.OUT_VALID}, 16'h0001);
        end
      end
    join
    repeat (4) @(negedge CLK);

    // Reset in the middle of a stalled stream, then check fresh latency.
    bus.OUT_READY = 1'b0;
    applyStimulus(1'b0, 15'h0010, 15'h0001, '{sum: 15'h0011, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
    applyStimulus(1'b0, 15'h0020, 15'h0002, '{sum: 15'h0022, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
    goIdle();
    #1;
    checkOutput("pre_reset_valid", {bus.OUT_VALID, bus.SUM}, 16'h8011);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("async_reset_valid", {15'b0, bus.OUT_VALID}, 16'h0000);
    checkOutput("async_reset_sum",   {1'b0, bus.SUM}, 16'h0000);
    checkOutput("async_reset_flags", {12'b0, bus.COUT, bus.OVF, bus.ZERO, bus.NEG}, 16'h0000);
    exp_q.delete();
    @(negedge CLK);
    RST_N         = 1'b1;
    bus.OUT_READY = 1'b1;
    applyStimulus(1'b0, 15'h0100, 15'h0023, '{sum: 15'h0123, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
    goIdle();
    #1;
    checkOutput("latency_cycle1", {15'b0, bus.OUT_VALID}, 16'h0000);
    @(negedge CLK);
    #1;
    checkOutput("latency_cycle2", {bus.OUT_VALID, bus.SUM}, 16'h8123);

    // Random sweep against the reference model with a jittery consumer.
    sweep_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          addsub = 1'($urandom_range(0, 1));
          ra     = W'($urandom);
          rb     = W'($urandom);
          applyStimulus(addsub, ra, rb, refModel(addsub, ra, rb));
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(negedge CLK);
          bus.OUT_READY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    goIdle();
    bus.OUT_READY = 1'b1;

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    repeat (2) @(negedge CLK);
    checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor: next generation of the 15-bit combinational CLA add/sub datapath.
- Generalised in operand width and lookahead group size; adds registered stages, valid/ready flow control and status flags (carry, overflow, zero, negative).
- Sits between the operand source and the result consumer in the ALU datapath.

Parameters:
- WIDTH, 15, operand/result width in bits (>= 2).
- GROUP, 3, CLA group size in bits (1..WIDTH); the last group is narrower when WIDTH is not a multiple of GROUP.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous reset, active-low.
- IN_VALID  input  1  operand beat valid.
- IN_READY  output  1  block accepts a beat this cycle.
- ADDSUB  input  1  0 = A+B, 1 = A-B.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- OUT_VALID  output  1  result beat valid.
- OUT_READY  input  1  consumer accepts the result.
- SUM  output  WIDTH  result.
- COUT  output  1  raw carry out of the MSB (1 = no borrow on subtract).
- OVF  output  1  signed overflow.
- ZERO  output  1  SUM == 0.
- NEG  output  1  SUM[WIDTH-1].

Behaviour:
- Reset: asserting RST_N low immediately clears both stage-valid bits and all output registers. OUT_VALID=0, SUM=0, COUT=0, OVF=0, ZERO=0, NEG=0. Reset mid-operation discards in-flight beats.
- Arithmetic:
  - Subtract is A + ~B + 1, with ADDSUB acting as carry-in and B XOR ADDSUB.
  - Per-bit p = a^b', g = a&b'. Group P/G are formed from these, and group carries come from a lookahead across groups; there is no ripple between groups.
  - OVF = carry into MSB XOR carry out of MSB.
  - COUT = carry out of MSB.
  - ZERO and NEG are computed from the pre-saturation SUM unless SATURATE_EN is defined.
- Pipeline (2 stages, latency 2 cycles from accepted beat to OUT_VALID):
  - Stage 1 registers {ADDSUB, per-bit p, per-bit g, group P/G}.
  - Stage 2 computes group carries and the sum, then registers SUM and the flags.
- Handshake:
  - A beat transfers on IN_VALID && IN_READY. A result transfers on OUT_VALID && OUT_READY.
  - IN_READY = !s1_valid || !OUT_VALID || OUT_READY. This is combinational from OUT_READY, with no other combinational path from input to output.
  - A stage advances when its downstream is empty or draining in the same cycle.
  - Full throughput is one beat per cycle with OUT_READY held high.
  - While OUT_VALID=1 and OUT_READY=0, SUM and all flags hold stable.
  - Results leave strictly in acceptance order. No beat is dropped or duplicated.
- Simultaneous accept and drain: in one cycle, stage 2 drains, stage 1 moves to stage 2, and a new beat enters stage 1.
- Input values are don't-care while IN_VALID=0. Stage registers are not updated with invalid data, so data stays frozen.

Optional Feature:
- Macro: CLA_ADDSUB_SATURATE_EN.
- Defined:
  - When OVF=1, SUM is clamped in stage 2: positive overflow (MSB of A' = 0) gives 0 followed by WIDTH-1 ones; negative overflow gives 1 followed by WIDTH-1 zeros.
  - OVF still reports 1. ZERO and NEG reflect the clamped SUM. Latency is unchanged.
- Undefined: SUM wraps modulo 2^WIDTH and no clamp logic is present.

Test Plan:
- WIDTH=15. ADD A=5, B=3, OUT_READY=1 -> 2 cycles later SUM=0x0008, COUT=0, OVF=0, ZERO=0, NEG=0.
- ADD A=0x3FFF, B=0x0001 -> SUM=0x4000, OVF=1, NEG=1, COUT=0. With CLA_ADDSUB_SATURATE_EN -> SUM=0x3FFF, OVF=1, NEG=0.
- SUB A=0x0000, B=0x0001 -> SUM=0x7FFF, COUT=0, OVF=0, NEG=1. SUB A=0x0005, B=0x0005 -> SUM=0, ZERO=1, COUT=1.
- SUB A=0x4000, B=0x0001 -> SUM=0x3FFF, COUT=1, OVF=1. With CLA_ADDSUB_SATURATE_EN -> SUM=0x4000, NEG=1.
- Backpressure:
  - Stimulus: send 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) and hold OUT_READY=0 for 3 cycles after the first OUT_VALID.
  - Expected: IN_READY drops once both stages are full, then SUM holds at 2.
  - After release: results come out as 2, 4, 6, 8 in order with no gaps at OUT_READY=1.
- Reset and group sweep:
  - Pulse RST_N low mid-stream while OUT_VALID=1 -> OUT_VALID and all outputs are 0 before the next CLK edge; the first beat after reset appears 2 cycles after acceptance.
  - Repeat a random add/sub sweep for GROUP=1, 4 and 15 against a reference model -> exact match on SUM and all flags.
